// File: rtl/semaforo_pkg.sv
// Shared definitions for the intersection input conditioner: pedestrian FSM
// state encoding, default parameter values and the counter width helper.
// The optional request timeout is enabled with SEMAFORO_PETICION_TIMEOUT_EN.
package semaforo_pkg;

    typedef enum logic {
        LIBRE     = 1'b0,
        PENDIENTE = 1'b1
    } estado_t;

    localparam int DEBOUNCE_CYCLES_DEF = 16;
    localparam int HOLD_CYCLES_DEF     = 50;
    localparam int TIMEOUT_CYCLES_DEF  = 1000;

    // Bits needed to hold any value from 0 up to max_value inclusive.
    function automatic int cnt_width(input int max_value);
        return (max_value < 1) ? 1 : $clog2(max_value + 1);
    endfunction

endpackage

// File: rtl/semaforo_antirrebote.sv
// Raw asynchronous input conditioner: 2-flop synchroniser, debounce counter,
// debounced level and a one-cycle pulse on each debounced rising edge.
module semaforo_antirrebote
    import semaforo_pkg::*;
#(
    parameter int DEBOUNCE_CYCLES = DEBOUNCE_CYCLES_DEF
)(
    input  logic clk,
    input  logic rst,
    input  logic entrada,
    output logic nivel,
    output logic subida
);

    localparam int              CW      = cnt_width(DEBOUNCE_CYCLES - 1);
    localparam logic [CW-1:0]   CNT_MAX = CW'(DEBOUNCE_CYCLES - 1);

    logic [1:0]    sync_reg;
    logic [CW-1:0] cnt_reg;
    logic          nivel_reg;
    logic          subida_reg;

    // Two-stage synchroniser for the asynchronous pin.
    always_ff @(posedge clk) begin
        if (rst) begin
            sync_reg <= 2'b00;
        end else begin
            sync_reg <= {sync_reg[0], entrada};
        end
    end

    // Count consecutive samples that disagree with the debounced level; flip
    // after DEBOUNCE_CYCLES of them and flag a rising edge when going high.
    always_ff @(posedge clk) begin
        if (rst) begin
            cnt_reg    <= '0;
            nivel_reg  <= 1'b0;
            subida_reg <= 1'b0;
        end else begin
            subida_reg <= 1'b0;
            if (sync_reg[1] == nivel_reg) begin
                cnt_reg <= '0;
            end else if (cnt_reg == CNT_MAX) begin
                cnt_reg    <= '0;
                nivel_reg  <= ~nivel_reg;
                subida_reg <= ~nivel_reg;
            end else begin
                cnt_reg <= cnt_reg + 1'b1;
            end
        end
    end

    assign nivel  = nivel_reg;
    assign subida = subida_reg;

endmodule

// File: rtl/semaforo_peticiones.sv
// Input-side conditioner for the intersection controller. Debounces vehicle
// loops and pedestrian buttons, stretches vehicle presence across short gaps
// and latches pedestrian requests until the red-light feedback rises.
// Define SEMAFORO_PETICION_TIMEOUT_EN to auto-clear stale requests after
// TIMEOUT_CYCLES and report it on timeout_a / timeout_b.
module semaforo_peticiones
    import semaforo_pkg::*;
#(
    parameter int DEBOUNCE_CYCLES = DEBOUNCE_CYCLES_DEF,
    parameter int HOLD_CYCLES     = HOLD_CYCLES_DEF
`ifdef SEMAFORO_PETICION_TIMEOUT_EN
    ,
    parameter int TIMEOUT_CYCLES  = TIMEOUT_CYCLES_DEF
`endif
)(
    input  logic clk,
    input  logic rst,
    input  logic detector_a,
    input  logic detector_b,
    input  logic boton_paso_a,
    input  logic boton_paso_b,
    input  logic rojo_a,
    input  logic rojo_b,
    output logic sensor_a,
    output logic sensor_b,
    output logic paso_a,
    output logic paso_b
`ifdef SEMAFORO_PETICION_TIMEOUT_EN
    ,
    output logic timeout_a,
    output logic timeout_b
`endif
);

    localparam int            HW        = cnt_width(HOLD_CYCLES);
    localparam logic [HW-1:0] HOLD_LOAD = HW'(HOLD_CYCLES);
`ifdef SEMAFORO_PETICION_TIMEOUT_EN
    localparam int            TW        = cnt_width(TIMEOUT_CYCLES - 1);
    localparam logic [TW-1:0] TIMER_MAX = TW'(TIMEOUT_CYCLES - 1);
`endif

    // Index 0 is street/crossing A, index 1 is B; the two are fully independent.
    logic [1:0] detector_raw;
    logic [1:0] boton_raw;
    logic [1:0] rojo_in;
    logic [1:0] sensor_vec;
    logic [1:0] paso_vec;
`ifdef SEMAFORO_PETICION_TIMEOUT_EN
    logic [1:0] timeout_vec;
`endif

    assign detector_raw = {detector_b, detector_a};
    assign boton_raw    = {boton_paso_b, boton_paso_a};
    assign rojo_in      = {rojo_b, rojo_a};

    genvar gi;
    generate
        for (gi = 0; gi < 2; gi++) begin : g_canal
            logic          det_nivel;
            logic          det_subida;
            logic          btn_nivel;
            logic          btn_subida;
            logic [HW-1:0] hold_reg;
            logic          sensor_reg;
            estado_t       state_reg;
            estado_t       state_next;
            logic          rojo_prev_reg;
            logic          press;
            logic          red_rise;
            logic          paso_bit;

            semaforo_antirrebote #(
                .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
            ) u_det (
                .clk     (clk),
                .rst     (rst),
                .entrada (detector_raw[gi]),
                .nivel   (det_nivel),
                .subida  (det_subida)
            );

            semaforo_antirrebote #(
                .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
            ) u_btn (
                .clk     (clk),
                .rst     (rst),
                .entrada (boton_raw[gi]),
                .nivel   (btn_nivel),
                .subida  (btn_subida)
            );

            // Vehicle presence: reload the hold while the loop is occupied
            // (a fresh rise is always accompanied by the high level), then
            // keep sensor high until the hold has counted down.
            always_ff @(posedge clk) begin
                if (rst) begin
                    hold_reg   <= '0;
                    sensor_reg <= 1'b0;
                end else if (det_nivel | det_subida) begin
                    hold_reg   <= HOLD_LOAD;
                    sensor_reg <= 1'b1;
                end else begin
                    sensor_reg <= (hold_reg != '0);
                    if (hold_reg != '0) begin
                        hold_reg <= hold_reg - 1'b1;
                    end
                end
            end

            // One press per debounced rising edge; red-rise marks service.
            assign press    = btn_subida & btn_nivel;
            assign red_rise = rojo_in[gi] & ~rojo_prev_reg;

            // Previous-cycle red feedback for red-rise detection.
            always_ff @(posedge clk) begin
                if (rst) begin
                    rojo_prev_reg <= 1'b0;
                end else begin
                    rojo_prev_reg <= rojo_in[gi];
                end
            end

`ifdef SEMAFORO_PETICION_TIMEOUT_EN
            logic [TW-1:0] timer_reg;
            logic          timeout_reg;
            logic          expira;

            // Timeout fires only when no red-rise arrives on the same cycle.
            assign expira = (state_reg == PENDIENTE) && (timer_reg == TIMER_MAX) && !red_rise;

            // Age of the pending request; held at zero while idle so it starts
            // from zero on entry to PENDIENTE.
            always_ff @(posedge clk) begin
                if (rst || state_reg == LIBRE) begin
                    timer_reg <= '0;
                end else begin
                    timer_reg <= timer_reg + 1'b1;
                end
            end

            // One-cycle pulse reporting an auto-cleared request.
            always_ff @(posedge clk) begin
                if (rst) begin
                    timeout_reg <= 1'b0;
                end else begin
                    timeout_reg <= expira;
                end
            end

            assign timeout_vec[gi] = timeout_reg;
`endif

            // Pedestrian FSM state register.
            always_ff @(posedge clk) begin
                if (rst) begin
                    state_reg <= LIBRE;
                end else begin
                    state_reg <= state_next;
                end
            end

            // Latch a press unless the crossing is already red; release on
            // red-rise, which also wins over a simultaneous press.
            always_comb begin
                state_next = state_reg;
                if (state_reg == LIBRE) begin
                    if (press && !rojo_in[gi]) begin
                        state_next = PENDIENTE;
                    end
                end else begin
                    if (red_rise) begin
                        state_next = LIBRE;
                    end
`ifdef SEMAFORO_PETICION_TIMEOUT_EN
                    else if (expira) begin
                        state_next = LIBRE;
                    end
`endif
                end
            end

            // Request output is the pending state itself.
            always_comb begin
                paso_bit = (state_reg == PENDIENTE);
            end

            assign sensor_vec[gi] = sensor_reg;
            assign paso_vec[gi]   = paso_bit;
        end
    endgenerate

    assign sensor_a = sensor_vec[0];
    assign sensor_b = sensor_vec[1];
    assign paso_a   = paso_vec[0];
    assign paso_b   = paso_vec[1];
`ifdef SEMAFORO_PETICION_TIMEOUT_EN
    assign timeout_a = timeout_vec[0];
    assign timeout_b = timeout_vec[1];
`endif

endmodule

// File: tb/tb_semaforo_peticiones.sv
// Directed bench for semaforo_peticiones with DEBOUNCE_CYCLES=4,
// HOLD_CYCLES=8, TIMEOUT_CYCLES=20. Timeout scenarios are compiled in when
// SEMAFORO_PETICION_TIMEOUT_EN is defined.
module tb_semaforo_peticiones;

    logic clk;
    logic rst;
    logic detector_a, detector_b;
    logic boton_paso_a, boton_paso_b;
    logic rojo_a, rojo_b;
    logic sensor_a, sensor_b, paso_a, paso_b;
`ifdef SEMAFORO_PETICION_TIMEOUT_EN
    logic timeout_a, timeout_b;
`endif

    int checks = 0;
    int errors = 0;

    semaforo_peticiones #(
        .DEBOUNCE_CYCLES(4),
        .HOLD_CYCLES(8)
`ifdef SEMAFORO_PETICION_TIMEOUT_EN
        ,
        .TIMEOUT_CYCLES(20)
`endif
    ) dut (
        .clk          (clk),
        .rst          (rst),
        .detector_a   (detector_a),
        .detector_b   (detector_b),
        .boton_paso_a (boton_paso_a),
        .boton_paso_b (boton_paso_b),
        .rojo_a       (rojo_a),
        .rojo_b       (rojo_b),
        .sensor_a     (sensor_a),
        .sensor_b     (sensor_b),
        .paso_a       (paso_a),
        .paso_b       (paso_b)
`ifdef SEMAFORO_PETICION_TIMEOUT_EN
        ,
        .timeout_a    (timeout_a),
        .timeout_b    (timeout_b)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Advance one clock; inputs change and outputs are sampled 1 unit after the edge.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Idle all inputs and hold reset for 3 edges; the last edge is cycle 0.
    task automatic apply_reset();
        rst = 1'b1;
        detector_a = 1'b0; detector_b = 1'b0;
        boton_paso_a = 1'b0; boton_paso_b = 1'b0;
        rojo_a = 1'b0; rojo_b = 1'b0;
        repeat (3) tick();
        rst = 1'b0;
    endtask

    task automatic test_reset();
        logic [3:0] exp;
        rst = 1'b1;
        detector_a = 1'b1; detector_b = 1'b1;
        boton_paso_a = 1'b1; boton_paso_b = 1'b1;
        rojo_a = 1'b0; rojo_b = 1'b0;
        for (int i = 0; i < 3; i++) begin
            tick();
            checks++;
            if ({sensor_a, sensor_b, paso_a, paso_b} !== 4'b0000) begin
                errors++;
                $display("FAIL reset_hold cycle=%0d got=%b expected=0000", i, {sensor_a, sensor_b, paso_a, paso_b});
            end
        end
        rst = 1'b0;
        for (int t = 1; t <= 8; t++) begin
            tick();
            exp = (t >= 7) ? 4'b1111 : 4'b0000;
            checks++;
            if ({sensor_a, sensor_b, paso_a, paso_b} !== exp) begin
                errors++;
                $display("FAIL reset_release t=%0d got=%b expected=%b", t, {sensor_a, sensor_b, paso_a, paso_b}, exp);
            end
        end
        $display("test_reset: outputs after release sa=%b sb=%b pa=%b pb=%b", sensor_a, sensor_b, paso_a, paso_b);
    endtask

    task automatic test_mid_reset();
        apply_reset();
        boton_paso_a = 1'b1;
        detector_b   = 1'b1;
        repeat (8) tick();
        checks++;
        if ({sensor_b, paso_a} !== 2'b11) begin
            errors++;
            $display("FAIL mid_reset_setup got=%b expected=11", {sensor_b, paso_a});
        end
        rst = 1'b1;
        tick();
        checks++;
        if ({sensor_a, sensor_b, paso_a, paso_b} !== 4'b0000) begin
            errors++;
            $display("FAIL mid_reset_clear got=%b expected=0000", {sensor_a, sensor_b, paso_a, paso_b});
        end
        rst = 1'b0;
        boton_paso_a = 1'b0;
        detector_b   = 1'b0;
        $display("test_mid_reset: pending request and hold dropped, pa=%b sb=%b", paso_a, sensor_b);
    endtask

    task automatic test_glitch();
        logic exp;
        apply_reset();
        boton_paso_a = 1'b1;
        for (int t = 1; t <= 12; t++) begin
            tick();
            if (t == 3) boton_paso_a = 1'b0;
            checks++;
            if (paso_a !== 1'b0) begin
                errors++;
                $display("FAIL glitch_reject t=%0d got=%b expected=0", t, paso_a);
            end
        end
        $display("test_glitch: 3-cycle press rejected, pa=%b", paso_a);
        boton_paso_a = 1'b1;
        for (int t = 1; t <= 12; t++) begin
            tick();
            if (t == 4) boton_paso_a = 1'b0;
            exp = (t >= 7);
            checks++;
            if (paso_a !== exp) begin
                errors++;
                $display("FAIL press_latency t=%0d got=%b expected=%b", t, paso_a, exp);
            end
        end
        $display("test_glitch: 4-cycle press latched, pa=%b", paso_a);
    endtask

    task automatic test_service();
        apply_reset();
        boton_paso_a = 1'b1;
        repeat (4) tick();
        boton_paso_a = 1'b0;
        repeat (10) tick();
        checks++;
        if (paso_a !== 1'b1) begin
            errors++;
            $display("FAIL service_latched got=%b expected=1", paso_a);
        end
        rojo_a = 1'b1;
        tick();
        checks++;
        if (paso_a !== 1'b0) begin
            errors++;
            $display("FAIL service_clear got=%b expected=0", paso_a);
        end
        $display("test_service: red rise served request, pa=%b", paso_a);
        // Press while red: ignored.
        boton_paso_a = 1'b1;
        for (int t = 1; t <= 13; t++) begin
            tick();
            if (t == 5) boton_paso_a = 1'b0;
            checks++;
            if (paso_a !== 1'b0) begin
                errors++;
                $display("FAIL press_while_red t=%0d got=%b expected=0", t, paso_a);
            end
        end
        rojo_a = 1'b0;
        repeat (3) tick();
        checks++;
        if (paso_a !== 1'b0) begin
            errors++;
            $display("FAIL press_while_red_after got=%b expected=0", paso_a);
        end
        $display("test_service: press during red ignored, pa=%b", paso_a);
        // Two presses while pending: one red rise clears both.
        for (int p = 0; p < 2; p++) begin
            boton_paso_a = 1'b1;
            repeat (4) tick();
            boton_paso_a = 1'b0;
            repeat (6) tick();
            checks++;
            if (paso_a !== 1'b1) begin
                errors++;
                $display("FAIL repeat_press p=%0d got=%b expected=1", p, paso_a);
            end
        end
        rojo_a = 1'b1;
        tick();
        rojo_a = 1'b0;
        repeat (2) tick();
        checks++;
        if (paso_a !== 1'b0) begin
            errors++;
            $display("FAIL no_counting got=%b expected=0", paso_a);
        end
        $display("test_service: repeated presses not counted, pa=%b", paso_a);
        // Button held across service: only one press event.
        boton_paso_a = 1'b1;
        repeat (8) tick();
        checks++;
        if (paso_a !== 1'b1) begin
            errors++;
            $display("FAIL held_press got=%b expected=1", paso_a);
        end
        rojo_a = 1'b1;
        tick();
        rojo_a = 1'b0;
        repeat (10) tick();
        checks++;
        if (paso_a !== 1'b0) begin
            errors++;
            $display("FAIL held_single_event got=%b expected=0", paso_a);
        end
        boton_paso_a = 1'b0;
        checks++;
        if (paso_b !== 1'b0) begin
            errors++;
            $display("FAIL crossing_independent got=%b expected=0", paso_b);
        end
        $display("test_service: held button gives one request, pa=%b pb=%b", paso_a, paso_b);
    endtask

    task automatic test_simultaneous();
        apply_reset();
        boton_paso_b = 1'b1;
        repeat (6) tick();
        rojo_b = 1'b1;
        for (int t = 7; t <= 12; t++) begin
            tick();
            checks++;
            if (paso_b !== 1'b0) begin
                errors++;
                $display("FAIL simultaneous t=%0d got=%b expected=0", t, paso_b);
            end
        end
        boton_paso_b = 1'b0;
        rojo_b = 1'b0;
        $display("test_simultaneous: red rise beat press, pb=%b", paso_b);
    endtask

    task automatic test_gap();
        logic exp;
        apply_reset();
        detector_a = 1'b1;
        for (int t = 1; t <= 45; t++) begin
            tick();
            if (t == 10) detector_a = 1'b0;
            if (t == 15) detector_a = 1'b1;
            if (t == 25) detector_a = 1'b0;
            exp = (t >= 7) && (t < 40);
            checks++;
            if (sensor_a !== exp) begin
                errors++;
                $display("FAIL gap_bridge t=%0d got=%b expected=%b", t, sensor_a, exp);
            end
            checks++;
            if (sensor_b !== 1'b0) begin
                errors++;
                $display("FAIL street_independent t=%0d got=%b expected=0", t, sensor_b);
            end
        end
        $display("test_gap: gap bridged and hold expired, sa=%b", sensor_a);
    endtask

`ifdef SEMAFORO_PETICION_TIMEOUT_EN
    task automatic test_timeout();
        logic exp_p, exp_t;
        // Unserved request auto-clears 20 cycles after latching.
        apply_reset();
        boton_paso_b = 1'b1;
        for (int t = 1; t <= 32; t++) begin
            tick();
            if (t == 4) boton_paso_b = 1'b0;
            exp_p = (t >= 7) && (t < 27);
            exp_t = (t == 27);
            checks++;
            if ({paso_b, timeout_b, timeout_a} !== {exp_p, exp_t, 1'b0}) begin
                errors++;
                $display("FAIL timeout t=%0d got=%b expected=%b", t, {paso_b, timeout_b, timeout_a}, {exp_p, exp_t, 1'b0});
            end
        end
        $display("test_timeout: request expired, pb=%b", paso_b);
        // Red rise on the expiry cycle wins: no pulse.
        apply_reset();
        boton_paso_b = 1'b1;
        for (int t = 1; t <= 32; t++) begin
            tick();
            if (t == 4) boton_paso_b = 1'b0;
            if (t == 26) rojo_b = 1'b1;
            exp_p = (t >= 7) && (t < 27);
            checks++;
            if ({paso_b, timeout_b} !== {exp_p, 1'b0}) begin
                errors++;
                $display("FAIL timeout_vs_red t=%0d got=%b expected=%b", t, {paso_b, timeout_b}, {exp_p, 1'b0});
            end
        end
        rojo_b = 1'b0;
        $display("test_timeout: red rise on expiry cycle, no pulse, pb=%b", paso_b);
    endtask
`endif

    initial begin
        rst = 1'b1;
        detector_a = 1'b0; detector_b = 1'b0;
        boton_paso_a = 1'b0; boton_paso_b = 1'b0;
        rojo_a = 1'b0; rojo_b = 1'b0;
        test_reset();
        test_mid_reset();
        test_glitch();
        test_service();
        test_simultaneous();
        test_gap();
`ifdef SEMAFORO_PETICION_TIMEOUT_EN
        test_timeout();
`endif
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    // Safety bound on total run time.
    initial begin
        #200000;
        $display("FAIL watchdog time limit reached");
        $fatal(1, "watchdog");
    end

endmodule
